multiplier_datapath_taint_track_word: RTL and testbench

Datapath for the sequential shift-add multiplier, with word-level predicate taint tracking. It sits directly downstream of the multiplier control FSM and holds three registers: multiplicand, multiplier and result/shift. It executes the control strobes (`rsload`, `rsclear`, `rsshr`, `mrld`, `mdld`) and returns the static multiplier word that the controller bit-tests. Every register carries one taint bit, and each taint bit is propagated whenever its data, or the control strobe governing it, is tainted.

---
 rtl/multiplier_pkg.sv | 19 +
 rtl/multiplier_datapath_taint_track_word_taint_reg_word.sv | 40 ++++
 rtl/multiplier_datapath_taint_track_word.sv | 89 ++++++++
 tb/tb_multiplier_datapath_taint_track_word.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared width default, controller state encoding and taint combine helper
package multiplier_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [2:0] {
      START = 3'd0,
      INIT  = 3'd1,
      SHIFT = 3'd2,
      NOP   = 3'd3,
      LOAD  = 3'd4,
      FINAL = 3'd5
   } ctrl_state_e;

   function automatic logic taint_or(input logic src_t, input logic strobe_t);
      return src_t | strobe_t;
   endfunction

endpackage

// File: rtl/multiplier_datapath_taint_track_word_taint_reg_word.sv
// taint_reg_word: load-enable word register whose taint follows the loaded data or a tainted enable
module taint_reg_word
   import multiplier_pkg::*;
#(
   parameter int W = WIDTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         en_t,
   input  logic [W-1:0] d,
   input  logic         d_t,
   output logic [W-1:0] q,
   output logic         q_t
);

   logic [W-1:0] q_q, q_d;
   logic         q_t_q, q_t_d;

   // next value: load or hold; a tainted enable taints the word even when it is not asserted
   always_comb begin
      q_d   = en ? d : q_q;
      q_t_d = taint_or(en ? d_t : q_t_q, en_t);
   end

   // state register, cleared immediately on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q   <= '0;
         q_t_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         q_t_q <= q_t_d;
      end
   end

   assign q   = q_q;
   assign q_t = q_t_q;

endmodule

// File: rtl/multiplier_datapath_taint_track_word.sv
// multiplier_datapath_taint_track_word: shift-add multiplier datapath with word-level predicate taint
module multiplier_datapath_taint_track_word
   import multiplier_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic               multiplicand_t,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               multiplier_t,
   input  logic               rsload,
   input  logic               rsload_t,
   input  logic               rsclear,
   input  logic               rsclear_t,
   input  logic               rsshr,
   input  logic               rsshr_t,
   input  logic               mrld,
   input  logic               mrld_t,
   input  logic               mdld,
   input  logic               mdld_t,
   output logic [WIDTH-1:0]   multiplierReg,
   output logic               multiplierReg_t,
   output logic [2*WIDTH-1:0] product,
   output logic               product_t
);

   localparam int W2 = 2 * WIDTH;

   logic [WIDTH-1:0] md;
   logic             md_t;
   logic [W2:0]      rs_q, rs_d;
   logic             rs_t_q, rs_t_d;
   logic             rs_src_t;

   taint_reg_word #(.W(WIDTH)) u_md (
      .clk (clk),
      .rst (rst),
      .en  (mdld),
      .en_t(mdld_t),
      .d   (multiplicand),
      .d_t (multiplicand_t),
      .q   (md),
      .q_t (md_t)
   );

   taint_reg_word #(.W(WIDTH)) u_mr (
      .clk (clk),
      .rst (rst),
      .en  (mrld),
      .en_t(mrld_t),
      .d   (multiplier),
      .d_t (multiplier_t),
      .q   (multiplierReg),
      .q_t (multiplierReg_t)
   );

   // result op by priority clear > add > shift > hold; the add reads the pre-edge md, bit W2 catches the carry
   always_comb begin
      rs_d     = rs_q;
      rs_src_t = rs_t_q;
      if (rsclear) begin
         rs_d     = '0;
         rs_src_t = 1'b0;
      end else if (rsload) begin
         rs_d[W2:WIDTH] = {1'b0, rs_q[W2-1:WIDTH]} + {1'b0, md};
         rs_src_t       = rs_t_q | md_t;
      end else if (rsshr) begin
         rs_d = rs_q >> 1;
      end
      rs_t_d = taint_or(rs_src_t, rsclear_t | rsload_t | rsshr_t);
   end

   // result register, discarded at once on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs_q   <= '0;
         rs_t_q <= 1'b0;
      end else begin
         rs_q   <= rs_d;
         rs_t_q <= rs_t_d;
      end
   end

   assign product   = rs_q[W2-1:0];
   assign product_t = rs_t_q;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// tb_multiplier_datapath_taint_track_word: directed vectors with a queue-based scoreboard
module tb_multiplier_datapath_taint_track_word;
   import multiplier_pkg::*;

   localparam logic [9:0] MDLD = 10'h200, MDLD_T = 10'h100, MRLD = 10'h080, MRLD_T = 10'h040;
   localparam logic [9:0] RSLD = 10'h020, RSLD_T = 10'h010, RSCLR = 10'h008, RSCLR_T = 10'h004;
   localparam logic [9:0] SHR = 10'h002, SHR_T = 10'h001;

   typedef struct {
      logic [13:0] v;
      string       nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] ctl = '0;
   logic [3:0] a = '0, b = '0;
   logic       at = 1'b0, bt = 1'b0;
   logic       mdld, mdld_t, mrld, mrld_t, rsload, rsload_t, rsclear, rsclear_t, rsshr, rsshr_t;
   logic [3:0] mr_o;
   logic       mr_t_o;
   logic [7:0] prod_o;
   logic       prod_t_o;
   logic [13:0] obs;
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;

   assign {mdld, mdld_t, mrld, mrld_t, rsload, rsload_t, rsclear, rsclear_t, rsshr, rsshr_t} = ctl;
   assign obs = {prod_o, prod_t_o, mr_o, mr_t_o};

   always #5 clk = ~clk;

   multiplier_datapath_taint_track_word #(.WIDTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .multiplicand   (a),
      .multiplicand_t (at),
      .multiplier     (b),
      .multiplier_t   (bt),
      .rsload         (rsload),
      .rsload_t       (rsload_t),
      .rsclear        (rsclear),
      .rsclear_t      (rsclear_t),
      .rsshr          (rsshr),
      .rsshr_t        (rsshr_t),
      .mrld           (mrld),
      .mrld_t         (mrld_t),
      .mdld           (mdld),
      .mdld_t         (mdld_t),
      .multiplierReg  (mr_o),
      .multiplierReg_t(mr_t_o),
      .product        (prod_o),
      .product_t      (prod_t_o)
   );

   task automatic check(input string nm, input logic [13:0] act, input logic [13:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got product=%h product_t=%b mr=%h mr_t=%b, want product=%h product_t=%b mr=%h mr_t=%b",
                  nm, act[13:6], act[5], act[4:1], act[0], req[13:6], req[5], req[4:1], req[0]);
      end
   endtask

   task automatic step(input logic [9:0] c, input logic [3:0] av, input logic avt, input logic [3:0] bv,
                       input logic bvt, input logic [7:0] p, input logic pt, input logic [3:0] m,
                       input logic mt, input string nm);
      exp_t e;
      @(negedge clk);
      ctl = c;
      a = av;
      at = avt;
      b = bv;
      bt = bvt;
      e.v = {p, pt, m, mt};
      e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #3;
      check("drain", {13'd0, sb.size() != 0}, 14'd0);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check(e.nm, obs, e.v);
      end
   end

   initial begin
      ctl = MDLD | MRLD | MRLD_T | RSLD;
      a = 4'hB; at = 1'b1; b = 4'hD; bt = 1'b1;
      #12 rst = 1'b0;
      #1 check("rst_async", obs, 14'd0);
      @(posedge clk); #1 check("rst_hold", obs, 14'd0);
      @(negedge clk); rst = 1'b1; ctl = '0;
      // 5 x 3
      step(MDLD | MRLD | RSCLR, 4'd5, 0, 4'd3, 0, 8'h00, 0, 4'd3, 0, "m53_init");
      step(RSLD, 0, 0, 0, 0, 8'h50, 0, 4'd3, 0, "m53_ld0");
      step(SHR, 0, 0, 0, 0, 8'h28, 0, 4'd3, 0, "m53_sh0");
      step(RSLD, 0, 0, 0, 0, 8'h78, 0, 4'd3, 0, "m53_ld1");
      step(SHR, 0, 0, 0, 0, 8'h3C, 0, 4'd3, 0, "m53_sh1");
      step(SHR, 0, 0, 0, 0, 8'h1E, 0, 4'd3, 0, "m53_sh2");
      step(SHR, 0, 0, 0, 0, 8'h0F, 0, 4'd3, 0, "m53_sh3");
      // 15 x 15 exercising the carry guard
      step(MDLD | MRLD | RSCLR, 4'hF, 0, 4'hF, 0, 8'h00, 0, 4'hF, 0, "mff_init");
      step(RSLD, 0, 0, 0, 0, 8'hF0, 0, 4'hF, 0, "mff_ld0");
      step(SHR, 0, 0, 0, 0, 8'h78, 0, 4'hF, 0, "mff_sh0");
      step(RSLD, 0, 0, 0, 0, 8'h68, 0, 4'hF, 0, "mff_ld1");
      step(SHR, 0, 0, 0, 0, 8'hB4, 0, 4'hF, 0, "mff_sh1_carry");
      step(RSLD, 0, 0, 0, 0, 8'hA4, 0, 4'hF, 0, "mff_ld2");
      step(SHR, 0, 0, 0, 0, 8'hD2, 0, 4'hF, 0, "mff_sh2");
      step(RSLD, 0, 0, 0, 0, 8'hC2, 0, 4'hF, 0, "mff_ld3");
      step(SHR, 0, 0, 0, 0, 8'hE1, 0, 4'hF, 0, "mff_final");
      // data taint on the multiplicand
      step(MDLD | MRLD | RSCLR, 4'd5, 1, 4'd3, 0, 8'h00, 0, 4'd3, 0, "dt_init");
      step(RSLD, 0, 0, 0, 0, 8'h50, 1, 4'd3, 0, "dt_ld0");
      step(SHR, 0, 0, 0, 0, 8'h28, 1, 4'd3, 0, "dt_sh0");
      step(RSLD, 0, 0, 0, 0, 8'h78, 1, 4'd3, 0, "dt_ld1");
      step(SHR, 0, 0, 0, 0, 8'h3C, 1, 4'd3, 0, "dt_sh1");
      step(SHR, 0, 0, 0, 0, 8'h1E, 1, 4'd3, 0, "dt_sh2");
      step(SHR, 0, 0, 0, 0, 8'h0F, 1, 4'd3, 0, "dt_final");
      // predicate taint on deasserted strobes
      step(MDLD | RSCLR, 4'd9, 0, 0, 0, 8'h00, 0, 4'd3, 0, "pt_clr");
      step(RSLD, 0, 0, 0, 0, 8'h90, 0, 4'd3, 0, "pt_ld");
      step(SHR_T, 0, 0, 0, 0, 8'h90, 1, 4'd3, 0, "pt_shr_t");
      step(10'd0, 0, 0, 0, 0, 8'h90, 1, 4'd3, 0, "pt_sticky");
      step(RSCLR, 0, 0, 0, 0, 8'h00, 0, 4'd3, 0, "pt_clear");
      step(MRLD_T, 0, 0, 4'd7, 0, 8'h00, 0, 4'd3, 1, "pt_mrld_t");
      step(10'd0, 0, 0, 0, 0, 8'h00, 0, 4'd3, 1, "pt_mr_sticky");
      step(MRLD, 0, 0, 4'd6, 0, 8'h00, 0, 4'd6, 0, "pt_mr_reload");
      step(MDLD_T, 4'd2, 0, 0, 0, 8'h00, 0, 4'd6, 0, "pt_mdld_t");
      step(RSLD, 0, 0, 0, 0, 8'h90, 1, 4'd6, 0, "pt_md_taint_add");
      step(RSCLR, 0, 0, 0, 0, 8'h00, 0, 4'd6, 0, "pt_clr2");
      step(RSLD_T, 0, 0, 0, 0, 8'h00, 1, 4'd6, 0, "pt_rsload_t");
      step(RSCLR | MDLD, 4'd5, 0, 0, 0, 8'h00, 0, 4'd6, 0, "pt_clr3");
      // priority between simultaneous strobes
      step(RSLD, 0, 0, 0, 0, 8'h50, 0, 4'd6, 0, "pr_ld");
      step(SHR, 0, 0, 0, 0, 8'h28, 0, 4'd6, 0, "pr_sh0");
      step(SHR, 0, 0, 0, 0, 8'h14, 0, 4'd6, 0, "pr_sh1");
      step(SHR, 0, 0, 0, 0, 8'h0A, 0, 4'd6, 0, "pr_sh2");
      step(SHR | MDLD, 4'hF, 0, 0, 0, 8'h05, 0, 4'd6, 0, "pr_sh3");
      step(RSLD, 0, 0, 0, 0, 8'hF5, 0, 4'd6, 0, "pr_f5");
      step(RSCLR | RSLD | SHR, 0, 0, 0, 0, 8'h00, 0, 4'd6, 0, "pr_clear_wins");
      step(RSLD | SHR, 0, 0, 0, 0, 8'hF0, 0, 4'd6, 0, "pr_add_wins");
      step(RSLD | MDLD, 4'd1, 0, 0, 0, 8'hE0, 0, 4'd6, 0, "pr_old_md");
      // reset mid-multiply
      step(MDLD | MRLD | RSCLR, 4'd7, 1, 4'd7, 1, 8'h00, 0, 4'd7, 1, "mr_init");
      step(RSLD, 0, 0, 0, 0, 8'h70, 1, 4'd7, 1, "mr_ld");
      drain();
      rst = 1'b0;
      #1 check("rst_mid", obs, 14'd0);
      @(negedge clk); rst = 1'b1; ctl = '0;
      step(MDLD | MRLD, 4'd3, 0, 4'd2, 0, 8'h00, 0, 4'd2, 0, "post_load");
      step(RSLD, 0, 0, 0, 0, 8'h30, 0, 4'd2, 0, "post_add");
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
